// File: rtl/byte_tx_arbiter.sv
// Two-channel byte arbiter with one-entry holding registers feeding a busy-handshake transmitter.
// Optional macro BYTE_TX_ARB_FIXED_PRIO_EN: channel 0 always wins contention (round-robin otherwise).
module byte_tx_arbiter #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_stb,
    input  logic [7:0] req0_data,
    input  logic       req1_stb,
    input  logic [7:0] req1_data,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [1:0] grant,
    output logic       req0_drop,
    output logic       req1_drop,
    output logic       tx_err
);
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state_r;
    logic [TW-1:0] timer_r;
    logic          last_r;
    logic [7:0]    hold0_r;
    logic [7:0]    hold1_r;
    logic          v0_r;
    logic          v1_r;
    logic          sel1_s;
    logic          take_s;
    logic          take0_s;
    logic          take1_s;

    // Channel selection and slot-take decode for the current IDLE cycle.
    always_comb begin
        sel1_s = 1'b0;
`ifdef BYTE_TX_ARB_FIXED_PRIO_EN
        if (v0_r) begin
            sel1_s = 1'b0;
        end else begin
            sel1_s = v1_r;
        end
`else
        if (v0_r && v1_r) begin
            sel1_s = ~last_r;
        end else begin
            sel1_s = v1_r;
        end
`endif
        take_s  = (state_r == IDLE) && (v0_r || v1_r);
        take0_s = take_s && !sel1_s;
        take1_s = take_s && sel1_s;
    end

    // Holding registers; a strobe into a full slot is dropped unless the FSM frees it on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold0_r   <= 8'h00;
            hold1_r   <= 8'h00;
            v0_r      <= 1'b0;
            v1_r      <= 1'b0;
            req0_drop <= 1'b0;
            req1_drop <= 1'b0;
        end else begin
            req0_drop <= 1'b0;
            req1_drop <= 1'b0;
            if (req0_stb) begin
                if (!v0_r || take0_s) begin
                    hold0_r <= req0_data;
                    v0_r    <= 1'b1;
                end else begin
                    req0_drop <= 1'b1;
                end
            end else if (take0_s) begin
                v0_r <= 1'b0;
            end else begin
                v0_r <= v0_r;
            end
            if (req1_stb) begin
                if (!v1_r || take1_s) begin
                    hold1_r <= req1_data;
                    v1_r    <= 1'b1;
                end else begin
                    req1_drop <= 1'b1;
                end
            end else if (take1_s) begin
                v1_r <= 1'b0;
            end else begin
                v1_r <= v1_r;
            end
        end
    end

    // Grant/handshake controller with registered sink-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            timer_r  <= '0;
            last_r   <= 1'b1;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            grant    <= 2'b00;
            tx_err   <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            tx_err   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (take_s) begin
                        tx_data  <= sel1_s ? hold1_r : hold0_r;
                        grant    <= sel1_s ? 2'b10 : 2'b01;
                        tx_start <= 1'b1;
                        timer_r  <= '0;
                        state_r  <= ACK;
                    end
                end
                ACK: begin
                    if (tx_busy) begin
                        state_r <= DRAIN;
                    end else if (timer_r == TIMER_LAST) begin
                        tx_err  <= 1'b1;
                        grant   <= 2'b00;
                        last_r  <= grant[1];
                        state_r <= IDLE;
                    end else begin
                        timer_r <= timer_r + TW'(1'b1);
                    end
                end
                DRAIN: begin
                    if (!tx_busy) begin
                        grant   <= 2'b00;
                        last_r  <= grant[1];
                        state_r <= IDLE;
                    end
                end
                default: begin
                    grant   <= 2'b00;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_byte_tx_arbiter.sv
// Directed self-checking bench for byte_tx_arbiter (ACK_TIMEOUT=4).
module tb_byte_tx_arbiter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_stb = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req1_stb = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [1:0] grant;
    logic       req0_drop;
    logic       req1_drop;
    logic       tx_err;

    int n_checks = 0;
    int n_pass = 0;
    int drop0_cnt = 0;
    int drop1_cnt = 0;

    byte_tx_arbiter #(.ACK_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_stb(req0_stb), .req0_data(req0_data),
        .req1_stb(req1_stb), .req1_data(req1_data),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
        .grant(grant), .req0_drop(req0_drop), .req1_drop(req1_drop), .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    // Drop pulse counters, sampled away from the active edge.
    always @(negedge clk) begin
        if (req0_drop === 1'b1) drop0_cnt++;
        if (req1_drop === 1'b1) drop1_cnt++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for tx_start, capture byte/grant, then act as a sink busy for 'hold' cycles.
    task automatic sink_serve(input int hold, output logic [7:0] data, output logic [1:0] gnt);
        int n = 0;
        while (tx_start !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (tx_start !== 1'b1) $display("FAIL sink_wait: tx_start=%b after %0d cycles, want 1", tx_start, n);
        else n_pass++;
        data = tx_data;
        gnt  = grant;
        tick();
        tx_busy = 1'b1;
        repeat (hold) tick();
        tx_busy = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        n_checks++; if (tx_start !== 1'b0) $display("FAIL rst_tx_start: got %b want 0", tx_start); else n_pass++;
        n_checks++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h want 00", tx_data); else n_pass++;
        n_checks++; if (grant !== 2'b00) $display("FAIL rst_grant: got %b want 00", grant); else n_pass++;
        n_checks++; if ({req0_drop, req1_drop, tx_err} !== 3'b000)
            $display("FAIL rst_pulses: got %b want 000", {req0_drop, req1_drop, tx_err}); else n_pass++;
        rst_n = 1'b1;
        repeat (2) tick();
        n_checks++; if ({tx_start, grant} !== 3'b000) $display("FAIL rst_idle: got %b want 000", {tx_start, grant}); else n_pass++;
    endtask

    task automatic test_contention(input logic [7:0] exp_a, input logic [7:0] exp_b);
        logic [7:0] d0, d1;
        logic [1:0] g0, g1;
        int dr0, dr1;
        dr0 = drop0_cnt;
        dr1 = drop1_cnt;
        repeat (2) tick();
        req0_stb = 1'b1; req0_data = 8'h11;
        req1_stb = 1'b1; req1_data = 8'h22;
        tick();
        req0_stb = 1'b0; req1_stb = 1'b0;
        sink_serve(2, d0, g0);
        sink_serve(2, d1, g1);
        n_checks++; if (d0 !== exp_a) $display("FAIL cont_first: got %h want %h", d0, exp_a); else n_pass++;
        n_checks++; if (d1 !== exp_b) $display("FAIL cont_second: got %h want %h", d1, exp_b); else n_pass++;
        n_checks++; if (g0 !== ((exp_a == 8'h11) ? 2'b01 : 2'b10)) $display("FAIL cont_grant: got %b for %h", g0, exp_a); else n_pass++;
        n_checks++; if ((drop0_cnt - dr0) + (drop1_cnt - dr1) !== 0)
            $display("FAIL cont_drop: got %0d drops want 0", (drop0_cnt - dr0) + (drop1_cnt - dr1)); else n_pass++;
    endtask

    task automatic test_single;
        int bad = 0;
        repeat (2) tick();
        req0_stb = 1'b1; req0_data = 8'hA5;
        tick();
        req0_stb = 1'b0;
        n_checks++; if (tx_start !== 1'b0) $display("FAIL single_early: got tx_start=%b want 0", tx_start); else n_pass++;
        tick();
        n_checks++; if ({tx_start, grant} !== 3'b101) $display("FAIL single_start: got start/grant %b want 101", {tx_start, grant}); else n_pass++;
        n_checks++; if (tx_data !== 8'hA5) $display("FAIL single_data: got %h want a5", tx_data); else n_pass++;
        tick();
        n_checks++; if (tx_start !== 1'b0) $display("FAIL single_pulse: got tx_start=%b want 0", tx_start); else n_pass++;
        tx_busy = 1'b1;
        repeat (10) begin
            tick();
            if (grant !== 2'b01 || tx_start !== 1'b0) bad++;
        end
        tx_busy = 1'b0;
        n_checks++; if (bad !== 0) $display("FAIL single_hold: %0d cycles with grant!=01 or stray start, want 0", bad); else n_pass++;
        tick();
        n_checks++; if (grant !== 2'b00) $display("FAIL single_release: got grant %b want 00", grant); else n_pass++;
        n_checks++; if (tx_data !== 8'hA5) $display("FAIL single_stable: got %h want a5", tx_data); else n_pass++;
    endtask

    task automatic test_overflow;
        logic [7:0] d;
        logic [1:0] g;
        int dr1;
        repeat (2) tick();
        dr1 = drop1_cnt;
        req1_stb = 1'b1; req1_data = 8'h01;
        tick();
        req1_stb = 1'b0;
        tick();
        n_checks++; if ({tx_start, grant, tx_data} !== {1'b1, 2'b10, 8'h01})
            $display("FAIL ovf_first: got start/grant/data %b/%b/%h want 1/10/01", tx_start, grant, tx_data); else n_pass++;
        tx_busy = 1'b1;
        req1_stb = 1'b1; req1_data = 8'h02;
        tick();
        req1_data = 8'h03;
        tick();
        req1_stb = 1'b0;
        n_checks++; if (req1_drop !== 1'b1) $display("FAIL ovf_drop: got %b want 1", req1_drop); else n_pass++;
        tick();
        n_checks++; if (req1_drop !== 1'b0) $display("FAIL ovf_drop_pulse: got %b want 0", req1_drop); else n_pass++;
        repeat (3) tick();
        tx_busy = 1'b0;
        sink_serve(2, d, g);
        n_checks++; if (d !== 8'h02) $display("FAIL ovf_second: got %h want 02", d); else n_pass++;
        n_checks++; if (drop1_cnt - dr1 !== 1) $display("FAIL ovf_drop_count: got %0d want 1", drop1_cnt - dr1); else n_pass++;
    endtask

    task automatic test_same_edge;
        logic [7:0] d0, d1;
        logic [1:0] g0, g1;
        int dr0;
        repeat (2) tick();
        dr0 = drop0_cnt;
        req0_stb = 1'b1; req0_data = 8'h33;
        tick();
        req0_data = 8'h44;
        tick();
        req0_stb = 1'b0;
        sink_serve(2, d0, g0);
        sink_serve(2, d1, g1);
        n_checks++; if ({d0, d1} !== 16'h3344) $display("FAIL same_edge_bytes: got %h %h want 33 44", d0, d1); else n_pass++;
        n_checks++; if (drop0_cnt - dr0 !== 0) $display("FAIL same_edge_drop: got %0d want 0", drop0_cnt - dr0); else n_pass++;
    endtask

    task automatic test_timeout;
        logic [7:0] d;
        logic [1:0] g;
        repeat (2) tick();
        req0_stb = 1'b1; req0_data = 8'h7E;
        tick();
        req0_stb = 1'b0;
        tick();
        n_checks++; if ({tx_start, grant, tx_data} !== {1'b1, 2'b01, 8'h7E})
            $display("FAIL to_start: got start/grant/data %b/%b/%h want 1/01/7e", tx_start, grant, tx_data); else n_pass++;
        req1_stb = 1'b1; req1_data = 8'h55;
        tick();
        req1_stb = 1'b0;
        tick();
        tick();
        n_checks++; if ({tx_err, grant} !== 3'b001) $display("FAIL to_early: got err/grant %b want 001", {tx_err, grant}); else n_pass++;
        tick();
        n_checks++; if ({tx_err, grant} !== 3'b100) $display("FAIL to_err: got err/grant %b want 100", {tx_err, grant}); else n_pass++;
        tick();
        n_checks++; if (tx_err !== 1'b0) $display("FAIL to_err_pulse: got %b want 0", tx_err); else n_pass++;
        n_checks++; if ({tx_start, grant, tx_data} !== {1'b1, 2'b10, 8'h55})
            $display("FAIL to_pending: got start/grant/data %b/%b/%h want 1/10/55", tx_start, grant, tx_data); else n_pass++;
        sink_serve(2, d, g);
    endtask

    task automatic test_reset_mid_drain;
        logic [7:0] d;
        logic [1:0] g;
        int starts = 0;
        repeat (2) tick();
        req1_stb = 1'b1; req1_data = 8'h66;
        tick();
        req1_stb = 1'b0;
        tick();
        tx_busy = 1'b1;
        req0_stb = 1'b1; req0_data = 8'h77;
        tick();
        req0_stb = 1'b0;
        n_checks++; if (grant !== 2'b10) $display("FAIL rmd_grant: got %b want 10", grant); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({tx_start, tx_data, grant, req0_drop, req1_drop, tx_err} !== 14'h0)
            $display("FAIL rmd_async: got %b want all zero", {tx_start, tx_data, grant, req0_drop, req1_drop, tx_err}); else n_pass++;
        repeat (2) tick();
        rst_n = 1'b1;
        tx_busy = 1'b0;
        repeat (6) begin
            tick();
            if (tx_start !== 1'b0 || grant !== 2'b00) starts++;
        end
        n_checks++; if (starts !== 0) $display("FAIL rmd_quiet: got %0d active cycles want 0", starts); else n_pass++;
        req1_stb = 1'b1; req1_data = 8'h88;
        tick();
        req1_stb = 1'b0;
        sink_serve(2, d, g);
        n_checks++; if ({d, g} !== {8'h88, 2'b10}) $display("FAIL rmd_new: got %h/%b want 88/10", d, g); else n_pass++;
    endtask

    initial begin
        test_reset();
`ifdef BYTE_TX_ARB_FIXED_PRIO_EN
        test_contention(8'h11, 8'h22);
        test_single();
        test_contention(8'h11, 8'h22);
`else
        test_contention(8'h11, 8'h22);
        test_single();
        test_contention(8'h22, 8'h11);
`endif
        test_overflow();
        test_same_edge();
        test_timeout();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
